// File: rtl/data_cache_if.sv
// CPU data-memory port and block-wide main-memory port of the data cache.
// The cache is the slave on the CPU side and drives the memory requests.
interface data_cache_if;
  // CPU side: a request is held stable while DATA_CACHE_BUSY_WAIT is high and
  // completes in the first cycle busy is low; the memory side holds MEM_BUSYWAIT
  // high while MEM_READ/MEM_WRITE is pending and completes at the posedge where
  // the request is sampled with MEM_BUSYWAIT low.
  logic [3:0]   memReadEn;
  logic [2:0]   memWriteEn;
  logic [31:0]  DATA_CACHE_ADDR;
  logic [31:0]  DATA_CACHE_DATA;
  logic [31:0]  DATA_CACHE_READ_DATA;
  logic         DATA_CACHE_BUSY_WAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDR;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
    output DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
    output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  modport master (
    output memReadEn, memWriteEn, DATA_CACHE_ADDR, DATA_CACHE_DATA,
    input  DATA_CACHE_READ_DATA, DATA_CACHE_BUSY_WAIT,
    input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// Hits complete with no stall; misses evict dirty lines and refill via a 128-bit port.
module data_cache #(
  parameter int SETS = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  data_cache_if.slave      bus,
  output logic [1:0]       state_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [127:0]      data_q [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              store_req, load_req, req, hit, store_hit, refill_done;
  logic [127:0]      line, store_line;
  logic [31:0]       word, load_val;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // A store takes priority when both enables are raised together.
  assign store_req = bus.memWriteEn[2];
  assign load_req  = bus.memReadEn[3] && !store_req;
  assign req       = load_req || store_req;

  assign idx     = bus.DATA_CACHE_ADDR[4 +: IDX_W];
  assign req_tag = bus.DATA_CACHE_ADDR[31 -: TAG_W];
  assign line    = data_q[idx];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

  assign word     = line[{bus.DATA_CACHE_ADDR[3:2], 5'b0} +: 32];
  assign byte_sel = word[{bus.DATA_CACHE_ADDR[1:0], 3'b0} +: 8];
  assign half_sel = word[{bus.DATA_CACHE_ADDR[1], 4'b0} +: 16];

  always_comb begin
    load_val = word;
    case (bus.memReadEn[2:0])
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'b0, byte_sel};
      3'b101:  load_val = {16'b0, half_sel};
      default: load_val = word;
    endcase
  end

  always_comb begin
    store_line = line;
    case (bus.memWriteEn[1:0])
      2'b00:   store_line[{bus.DATA_CACHE_ADDR[3:0], 3'b0} +: 8] = bus.DATA_CACHE_DATA[7:0];
      2'b01:   store_line[{bus.DATA_CACHE_ADDR[3:1], 4'b0} +: 16] = bus.DATA_CACHE_DATA[15:0];
      default: store_line[{bus.DATA_CACHE_ADDR[3:2], 5'b0} +: 32] = bus.DATA_CACHE_DATA;
    endcase
  end

  assign bus.DATA_CACHE_READ_DATA = (state_q == IDLE && load_req && hit) ? load_val : 32'b0;
  assign bus.DATA_CACHE_BUSY_WAIT = req && (state_q != IDLE || !hit);
  assign store_hit   = (state_q == IDLE) && store_req && hit;
  assign refill_done = (state_q == REFILL) && !bus.MEM_BUSYWAIT;
  assign state_o     = state_q;

  always_comb begin
    state_d           = state_q;
    bus.MEM_READ      = 1'b0;
    bus.MEM_WRITE     = 1'b0;
    bus.MEM_ADDR      = '0;
    bus.MEM_WRITEDATA = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        bus.MEM_WRITE     = 1'b1;
        bus.MEM_ADDR      = {tag_q[idx], idx};
        bus.MEM_WRITEDATA = line;
        if (!bus.MEM_BUSYWAIT) state_d = REFILL;
      end
      REFILL: begin
        bus.MEM_READ = 1'b1;
        bus.MEM_ADDR = bus.DATA_CACHE_ADDR[31:4];
        if (!bus.MEM_BUSYWAIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; an abandoned refill must not touch them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (refill_done) begin
        tag_q[idx]  <= req_tag;
        data_q[idx] <= bus.MEM_READDATA;
      end else if (store_hit) begin
        data_q[idx] <= store_line;
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Directed scoreboard bench for data_cache: load results and memory requests are
// queued at issue time and checked by monitors when the cache presents them.
module tb_data_cache;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] state_dbg;

  data_cache_if bus();

  data_cache #(.SETS(8)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [60:0] mem_exp_q[$];

  // main-memory model with programmable latency
  logic [127:0] mem [256];
  int           mem_cnt = 0;
  int           mem_lat = 1;
  logic         mem_ready = 1'b0;

  assign bus.MEM_BUSYWAIT = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt < mem_lat - 1);
  assign bus.MEM_READDATA = mem[bus.MEM_ADDR[7:0]];

  always @(posedge CLK) begin
    if (RESET) begin
      mem_cnt <= 0;
      if (!mem_ready) begin
        for (int i = 0; i < 256; i++) mem[i] <= {4{32'h5A5A0000 | 32'(i)}};
        mem[4] <= {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211};
        mem_ready <= 1'b1;
      end
    end else if (bus.MEM_READ || bus.MEM_WRITE) begin
      if (bus.MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
      else begin
        mem_cnt <= 0;
        if (bus.MEM_WRITE) mem[bus.MEM_ADDR[7:0]] <= bus.MEM_WRITEDATA;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: load results
  logic [31:0] e_load;
  always @(negedge CLK) begin
    if (!RESET && bus.memReadEn[3] && !bus.memWriteEn[2] && !bus.DATA_CACHE_BUSY_WAIT) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got %h expected no load", bus.DATA_CACHE_READ_DATA);
      end else begin
        e_load = exp_q.pop_front();
        check("load_data", {96'b0, bus.DATA_CACHE_READ_DATA}, {96'b0, e_load});
      end
    end
  end

  // scoreboard monitor: memory requests {is_write, block address, evicted word 0}
  logic        prev_r = 1'b0, prev_w = 1'b0;
  logic [60:0] e_mem;
  task automatic mem_pop(input logic is_wr);
    if (mem_exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_mem_req: got wr=%0b addr=%h expected none", is_wr, bus.MEM_ADDR);
    end else begin
      e_mem = mem_exp_q.pop_front();
      check("mem_req", {99'b0, is_wr, bus.MEM_ADDR}, {99'b0, e_mem[60:32]});
      if (is_wr) check("evict_word0", {96'b0, bus.MEM_WRITEDATA[31:0]}, {96'b0, e_mem[31:0]});
    end
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.MEM_WRITE && !prev_w) mem_pop(1'b1);
      if (bus.MEM_READ && !prev_r) mem_pop(1'b0);
    end
    prev_w <= bus.MEM_WRITE;
    prev_r <= bus.MEM_READ;
  end

  // driver: called just after a posedge, returns just after the completing posedge
  task automatic run_req(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] data, input int exp_busy, input string name);
    int  cnt;
    bit  done;
    bus.memReadEn       = rd;
    bus.memWriteEn      = wr;
    bus.DATA_CACHE_ADDR = addr;
    bus.DATA_CACHE_DATA = data;
    cnt  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (bus.DATA_CACHE_BUSY_WAIT) cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected completion", name, cnt);
    end else begin
      check($sformatf("%s_busy", name), 128'(cnt), 128'(exp_busy));
    end
    @(posedge CLK);
    #1;
    bus.memReadEn  = 4'b0;
    bus.memWriteEn = 3'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                      input int exp_busy, input string name);
    exp_q.push_back(exp);
    run_req({1'b1, f3}, 3'b000, addr, 32'h0, exp_busy, name);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data,
                       input int exp_busy, input string name);
    run_req(4'b0, {1'b1, sz}, addr, data, exp_busy, name);
  endtask

  task automatic exp_mem(input logic is_wr, input logic [27:0] a, input logic [31:0] w0);
    mem_exp_q.push_back({is_wr, a, w0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    bus.memReadEn       = 4'b0;
    bus.memWriteEn      = 3'b0;
    bus.DATA_CACHE_ADDR = 32'h0;
    bus.DATA_CACHE_DATA = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy",   {127'b0, bus.DATA_CACHE_BUSY_WAIT}, 128'h0);
    check("rst_rdata",  {96'b0, bus.DATA_CACHE_READ_DATA}, 128'h0);
    check("rst_mem_rd", {127'b0, bus.MEM_READ}, 128'h0);
    check("rst_mem_wr", {127'b0, bus.MEM_WRITE}, 128'h0);
    check("rst_maddr",  {100'b0, bus.MEM_ADDR}, 128'h0);
    check("rst_wdata",  bus.MEM_WRITEDATA, 128'h0);
    check("rst_state",  {126'b0, state_dbg}, 128'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // cold miss, latency 5: 1 IDLE miss cycle + 5 refill cycles
    mem_lat = 5;
    exp_mem(1'b0, 28'h0000004, 32'h0);
    load(3'b010, 32'h40, 32'h44332211, 6, "lw_cold_miss");

    // hit path, sign/zero extension and alignment
    load(3'b000, 32'h4B, 32'hFFFFFFCC, 0, "lb_4b");
    load(3'b100, 32'h4B, 32'h000000CC, 0, "lbu_4b");
    load(3'b001, 32'h46, 32'hFFFF8877, 0, "lh_46");
    load(3'b101, 32'h46, 32'h00008877, 0, "lhu_46");
    load(3'b001, 32'h47, 32'hFFFF8877, 0, "lh_47");
    load(3'b000, 32'h40, 32'h00000011, 0, "lb_40");
    load(3'b010, 32'h4C, 32'h00FFEEDD, 0, "lw_4c");

    // store hits: byte and halfword merge
    store(2'b00, 32'h41, 32'hFFFFFFAB, 0, "sb_41");
    load(3'b010, 32'h40, 32'h4433AB11, 0, "lw_after_sb");
    store(2'b01, 32'h4E, 32'h1234BEEF, 0, "sh_4e");
    load(3'b010, 32'h4C, 32'hBEEFEEDD, 0, "lw_after_sh");

    // dirty eviction: write back block 0x4, then refill block 0x44
    store(2'b10, 32'h40, 32'h12345678, 0, "sw_40");
    mem_lat = 3;
    exp_mem(1'b1, 28'h0000004, 32'h12345678);
    exp_mem(1'b0, 28'h0000044, 32'h0);
    load(3'b010, 32'h440, 32'h5A5A0044, 7, "lw_evict");
    check("evicted_block", mem[4], {32'hBEEFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h12345678});
    exp_mem(1'b0, 28'h0000004, 32'h0);
    load(3'b010, 32'h40, 32'h12345678, 4, "lw_reload");

    // store miss on a clean line: refill, then merge in the IDLE hit cycle
    mem_lat = 2;
    exp_mem(1'b0, 28'h0000008, 32'h0);
    store(2'b10, 32'h80, 32'hDEADBEEF, 3, "sw_miss");
    load(3'b010, 32'h80, 32'hDEADBEEF, 0, "lw_80");
    load(3'b010, 32'h84, 32'h5A5A0008, 0, "lw_84");

    // both enables: the store wins and no load result is produced
    run_req(4'b1010, 3'b110, 32'h84, 32'h11112222, 0, "ld_st_both");
    load(3'b010, 32'h84, 32'h11112222, 0, "lw_84_after_both");

    // unlisted funct3 codes behave as word accesses
    load(3'b011, 32'h80, 32'hDEADBEEF, 0, "ld_f3_011");
    store(2'b11, 32'h88, 32'hCAFEF00D, 0, "st_sz_11");
    load(3'b010, 32'h88, 32'hCAFEF00D, 0, "lw_88");

    // reset in the middle of a refill
    mem_lat = 10;
    exp_mem(1'b0, 28'h000000C, 32'h0);
    bus.memReadEn       = 4'b1010;
    bus.DATA_CACHE_ADDR = 32'hC0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    bus.memReadEn = 4'b0;
    @(negedge CLK);
    check("pre_rst_mem_rd", {127'b0, bus.MEM_READ}, 128'h1);
    @(posedge CLK);
    @(negedge CLK);
    check("mid_rst_mem_rd", {127'b0, bus.MEM_READ}, 128'h0);
    check("mid_rst_state",  {126'b0, state_dbg}, 128'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    mem_lat = 2;
    exp_mem(1'b0, 28'h000000C, 32'h0);
    load(3'b010, 32'hC0, 32'h5A5A000C, 3, "lw_c0_after_rst");
    exp_mem(1'b0, 28'h0000008, 32'h0);
    load(3'b010, 32'h80, 32'h5A5A0008, 3, "lw_80_after_rst");

    repeat (3) @(posedge CLK);
    check("load_queue_empty", 128'(exp_q.size()), 128'h0);
    check("mem_queue_empty",  128'(mem_exp_q.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
